muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle controller and iterative datapath for the RV32M MUL/DIV/REM
//   group. It sits beside the single-cycle ALU in the execute stage and
//   accepts one operation at a time. While the operation runs it holds the
//   pipeline with `stall`, then presents a registered result for one cycle.
//   Iteration is shift-add for multiply and restoring division for divide,
//   one bit per cycle, on operand magnitudes.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width (W); iteration count = W
// PORTS
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous reset, active low
//   start   in   1   execute stage holds an M-extension op; sampled only in IDLE
//   op      in   3   funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                    100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcA    in   W   rs1 operand (dividend / multiplicand)
//   SrcB    in   W   rs2 operand (divisor / multiplier)
//   flush   in   1   kill in-flight op (branch/jump redirect)
//   stall   out  1   freeze PC/IF/ID/EX registers (combinational)
//   busy    out  1   state != IDLE
//   valid   out  1   result valid; high for exactly the DONE cycle
//   result  out  W   registered result; meaningful only while valid=1
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; all registers zeroed
//     - stall=0, busy=0, valid=0, result=0
//   States and transitions:
//     - IDLE->COMPUTE when start=1 and the op is not a fast case
//     - IDLE->DONE when start=1 and the op is a fast case
//     - COMPUTE: counter runs W-1..0; ->DONE after W cycles
//     - DONE->IDLE unconditionally
//   Timing (start sampled at edge T):
//     - operands and op are latched at edge T
//     - normal op: COMPUTE for T+1..T+W, DONE at T+W+1 (latency W+1)
//     - fast case: DONE at T+1
//   stall:
//     - = (IDLE & start & !flush) | COMPUTE
//     - low in DONE, so EX advances on the same edge it consumes result
//   start:
//     - ignored in COMPUTE and DONE
//     - the next op starts from IDLE at the earliest one cycle after DONE
//   flush:
//     - any state -> IDLE at the next edge
//     - valid stays 0 for the killed op; stall falls combinationally at once
//     - flush+start together in IDLE: start is ignored
//   Signed ops:
//     - latch |SrcA| and |SrcB| per op signedness (MULHSU: A signed, B unsigned)
//     - record result sign; the unsigned core runs on magnitudes
//     - two's-complement fix-up is applied when result is registered at DONE entry
//   Multiply:
//     - 2W-bit accumulator
//     - MUL returns product[W-1:0]; MULH/MULHSU/MULHU return product[2W-1:W]
//   Divide (restoring, one quotient bit per cycle):
//     - quotient sign = signA^signB
//     - remainder sign = signA (RISC-V truncation semantics)
//   Fast cases (no COMPUTE):
//     - divisor=0: DIV/DIVU -> all ones; REM/REMU -> SrcA
//     - signed overflow (SrcA=0x8000_0000, SrcB=-1): DIV -> 0x8000_0000; REM -> 0
//   Reset mid-operation: immediate return to the reset values; no partial result
//     is ever exposed.
// TESTING
//   1. MUL 7*6 at edge T -> stall high T..T+32, valid=1, result=42 at T+33 only.
//   2. MULH 0xFFFF_FFFF*0xFFFF_FFFF -> 0; MULHU same operands -> 0xFFFF_FFFE;
//      MULHSU -1*2 -> 0xFFFF_FFFF.
//   3. DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
//   4. DIV 5/0 -> 0xFFFF_FFFF and REM 5/0 -> 5, each valid at T+1;
//      DIV 0x8000_0000/-1 -> 0x8000_0000 at T+1.
//   5. Start DIVU; assert flush at T+10 -> IDLE at T+11, stall=0 that cycle,
//      no valid pulse; a new MUL 3*3 then returns 9.
//   6. Start MUL; drop rst_n at T+5 (asynchronous, mid-cycle) -> all outputs 0
//      immediately; after release, start is accepted normally.
//      Also check: start held high during COMPUTE/DONE launches no second op.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Multi-cycle controller and iterative datapath for the RV32M MUL/DIV/REM
//   group. Accepts one operation at a time from the execute stage, holds the
//   pipeline with `stall` while it iterates, then presents a registered result
//   together with a one-cycle `valid` pulse.
//
//   Multiply: shift-add, MSB of the multiplier first, one bit per cycle.
//   Divide:   restoring division, one quotient bit per cycle.
//   Both run on operand magnitudes. The sign fix-up is applied when the result
//   is registered.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous reset, active low
//   start   in   1  M-extension op present; sampled only in IDLE
//   op      in   3  funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   SrcA    in   W  rs1 operand (multiplicand / dividend)
//   SrcB    in   W  rs2 operand (multiplier / divisor)
//   flush   in   1  kill the in-flight op and return to IDLE
//   stall   out  1  freeze upstream pipeline registers (combinational)
//   busy    out  1  state != IDLE (registered)
//   valid   out  1  result valid, high for exactly the DONE cycle (registered)
//   result  out  W  registered result, driven to zero outside DONE
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [W-1:0]    ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]    ONES_W   = {W{1'b1}};
  localparam logic [W-1:0]    MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [2*W-1:0]  ZERO_2W  = {(2*W){1'b0}};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Two's-complement negate of a W-bit value when requested.
  function automatic logic [W-1:0] neg_if_w(input logic [W-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  // Two's-complement negate of a 2W-bit value when requested.
  function automatic logic [2*W-1:0] neg_if_2w(input logic [2*W-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  state_t           state_r;
  logic [2:0]       op_r;
  logic [W-1:0]     mag_a_r;
  logic [W-1:0]     mag_b_r;
  logic             neg_res_r;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   acc_r;
  logic             busy_r;
  logic             valid_r;
  logic [W-1:0]     result_r;

  logic             sign_a_s;
  logic             sign_b_s;
  logic [W-1:0]     mag_a_s;
  logic [W-1:0]     mag_b_s;
  logic             neg_res_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic             fast_s;
  logic [W-1:0]     fast_res_s;

  logic [W:0]       hi_s;
  logic [2*W-1:0]   acc_step_s;
  logic [2*W-1:0]   prod_fix_s;
  logic [W-1:0]     final_res_s;

  // Operand decode at issue: signedness, magnitudes and fast-case detection.
  always_comb begin
    sign_a_s   = 1'b0;
    sign_b_s   = 1'b0;
    fast_res_s = ZERO_W;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        sign_a_s = SrcA[W-1];
        sign_b_s = SrcB[W-1];
      end
      OP_MULHSU: begin
        sign_a_s = SrcA[W-1];
        sign_b_s = 1'b0;
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    mag_a_s    = neg_if_w(SrcA, sign_a_s);
    mag_b_s    = neg_if_w(SrcB, sign_b_s);
    // Remainder takes the dividend's sign; everything else the product of signs.
    neg_res_s  = (op[2] & op[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
    div_zero_s = op[2] & (SrcB == ZERO_W);
    ovf_s      = ((op == OP_DIV) || (op == OP_REM)) && (SrcA == MIN_NEG) && (SrcB == ONES_W);
    fast_s     = div_zero_s | ovf_s;
    if (div_zero_s) begin
      fast_res_s = op[1] ? SrcA : ONES_W;
    end else if (ovf_s) begin
      fast_res_s = op[1] ? ZERO_W : MIN_NEG;
    end else begin
      fast_res_s = ZERO_W;
    end
  end

  // One iteration step of the shared accumulator (multiply or divide).
  always_comb begin
    // Partial remainder after the left shift needs one extra bit for the compare.
    hi_s       = acc_r[2*W-1:W-1];
    acc_step_s = acc_r;
    if (op_r[2]) begin
      if (hi_s >= {1'b0, mag_b_r}) begin
        acc_step_s = {hi_s[W-1:0] - mag_b_r, acc_r[W-2:0], 1'b1};
      end else begin
        acc_step_s = {hi_s[W-1:0], acc_r[W-2:0], 1'b0};
      end
    end else begin
      // Multiplier consumed MSB first: shift partial product, then add.
      if (mag_b_r[cnt_r]) begin
        acc_step_s = {acc_r[2*W-2:0], 1'b0} + {ZERO_W, mag_a_r};
      end else begin
        acc_step_s = {acc_r[2*W-2:0], 1'b0};
      end
    end
  end

  // Final result selection with sign fix-up, taken from the last step.
  always_comb begin
    prod_fix_s  = neg_if_2w(acc_step_s, neg_res_r);
    final_res_s = ZERO_W;
    case (op_r)
      OP_MUL:                       final_res_s = prod_fix_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res_s = prod_fix_s[2*W-1:W];
      OP_DIV, OP_DIVU:              final_res_s = neg_if_w(acc_step_s[W-1:0], neg_res_r);
      OP_REM, OP_REMU:              final_res_s = neg_if_w(acc_step_s[2*W-1:W], neg_res_r);
      default:                      final_res_s = ZERO_W;
    endcase
  end

  // Pipeline hold: drops at once on flush or reset, and is low in DONE.
  always_comb begin
    if (!rst_n || flush) begin
      stall = 1'b0;
    end else begin
      stall = ((state_r == IDLE) & start) | (state_r == COMPUTE);
    end
  end

  assign busy   = busy_r;
  assign valid  = valid_r;
  assign result = result_r;

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      op_r      <= 3'b000;
      mag_a_r   <= ZERO_W;
      mag_b_r   <= ZERO_W;
      neg_res_r <= 1'b0;
      cnt_r     <= CNT_ZERO;
      acc_r     <= ZERO_2W;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      result_r  <= ZERO_W;
    end else if (flush) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r  <= 1'b0;
          result_r <= ZERO_W;
          if (start) begin
            op_r      <= op;
            mag_a_r   <= mag_a_s;
            mag_b_r   <= mag_b_s;
            neg_res_r <= neg_res_s;
            cnt_r     <= CNT_LAST;
            // Division seeds the low half with the dividend magnitude.
            acc_r     <= op[2] ? {ZERO_W, mag_a_s} : ZERO_2W;
            busy_r    <= 1'b1;
            if (fast_s) begin
              state_r  <= DONE;
              valid_r  <= 1'b1;
              result_r <= fast_res_s;
            end else begin
              state_r  <= COMPUTE;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        COMPUTE: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ZERO) begin
            state_r  <= DONE;
            valid_r  <= 1'b1;
            result_r <= final_res_s;
          end else begin
            state_r <= COMPUTE;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          valid_r  <= 1'b0;
          result_r <= ZERO_W;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          valid_r  <= 1'b0;
          result_r <= ZERO_W;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed self-checking bench for muldiv_sequencer. Expected results are
//   pushed to a scoreboard queue at issue and popped when valid is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .SrcA   (src_a),
    .SrcB   (src_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it to its valid pulse; lat counts edges from issue.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp,
                        input int lat, input bit hold);
    int cyc;
    bit seen;
    logic [W-1:0] e;
    op = o; src_a = a; src_b = b; start = 1'b1;
    exp_q.push_back(exp);
    #1 check({tag, "_stall_issue"}, stall, 1);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      cyc++;
      if (valid) begin
        seen = 1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, result, e);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_stall_done"}, stall, 0);
        check({tag, "_busy_done"}, busy, 1);
      end else begin
        check({tag, "_stall_busy"}, {stall, busy}, 2'b11);
      end
    end
    if (!seen) check({tag, "_valid_timeout"}, cyc, lat);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid_single"}, valid, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
    src_a = 32'h0; src_b = 32'h0;

    // Reset state
    @(posedge clk); #1;
    check("reset_outputs", {29'h0, stall, busy, valid}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply
    run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,        33, 0);
    run_op("mulh_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,         33, 0);
    run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  33, 0);
    run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,  33, 0);
    run_op("mul_m3x5",    3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  33, 0);
    run_op("mulh_min2",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000,  33, 0);

    // Divide / remainder
    run_op("div_m7d2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  33, 0);
    run_op("rem_m7d2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  33, 0);
    run_op("divu_100d7",  3'b101, 32'd100,      32'd7,        32'd14,        33, 0);
    run_op("remu_100d7",  3'b111, 32'd100,      32'd7,        32'd2,         33, 0);
    run_op("div_7dm2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  33, 0);
    run_op("rem_7dm2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,         33, 0);
    run_op("divu_max_d1", 3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  33, 0);
    run_op("div_min_d1",  3'b100, 32'h80000000, 32'd1,        32'h80000000,  33, 0);

    // Fast cases
    run_op("div_5d0",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF,  1, 0);
    run_op("rem_5d0",     3'b110, 32'd5,        32'd0,        32'd5,         1, 0);
    run_op("divu_9d0",    3'b101, 32'd9,        32'd0,        32'hFFFFFFFF,  1, 0);
    run_op("remu_9d0",    3'b111, 32'd9,        32'd0,        32'd9,         1, 0);
    run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1, 0);
    run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,         1, 0);

    // start held through COMPUTE and DONE launches nothing extra
    run_op("mul_hold",    3'b000, 32'd11,       32'd13,       32'd143,       33, 1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("hold_no_second_op", pulses, 0);
    check("hold_idle", busy, 0);

    // Flush mid-DIVU
    op = 3'b101; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_stall_comb", stall, 0);
    check("flush_busy_before", busy, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {29'h0, stall, busy, valid}, 32'h0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("flush_no_valid", pulses, 0);
    run_op("mul_3x3_after_flush", 3'b000, 32'd3, 32'd3, 32'd9, 33, 0);

    // flush together with start in IDLE: start ignored
    op = 3'b000; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    #1 check("flush_start_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {30'h0, busy, valid}, 32'h0);

    // Asynchronous reset mid-MUL
    op = 3'b000; src_a = 32'd1234; src_b = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {29'h0, stall, busy, valid}, 32'h0);
    check("async_reset_result", result, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("reset_no_partial", pulses, 0);
    run_op("mul_5x5_after_reset", 3'b000, 32'd5, 32'd5, 32'd25, 33, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
